debounce_pulse: RTL and testbench

Conditions one raw, asynchronous event input (button, comparator, external flag) into a clean single-cycle pulse. It sits directly upstream of the sticky set/clear event latch.
- Stages: synchronise the input, debounce it with a stability counter, emit one-cycle rise/fall pulses.
- `rise_pulse` drives the latch's set input, so one physical event sets the latch exactly once regardless of contact bounce.

---
 rtl/debounce_pulse.sv | 111 +++++++++++
 tb/tb_debounce_pulse.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Debounces a raw asynchronous input into an accepted level with one-cycle
// rise/fall pulses, for feeding a sticky set/clear event latch.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic q_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI  = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_level_q, q_level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Bit 0 is the first synchroniser stage; only this chain sees din.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    q_level_d = q_level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (!en) begin
      // Disabled: park in the idle state of the accepted level, no pulses.
      state_d = q_level_q ? IDLE_HI : IDLE_LO;
    end else begin
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_d = IDLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE_HI;
            q_level_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_d = IDLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE_LO;
            q_level_d = 1'b0;
            fall_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      q_level_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_level_q <= q_level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign q_level    = q_level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: constant vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a run-length model.
module tb_debounce_pulse;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int CW     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic en  = 1'b1;
  logic q_level, rise_pulse, fall_pulse, busy;

  debounce_pulse #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .q_level(q_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: din delayed SYNC edges, accepted level, and length of the current
  // enabled run of samples disagreeing with the accepted level.
  logic [SYNC-1:0] m_hist = '0;
  logic m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;

  int seq_idx, rise_cnt, fall_cnt, rise_at;

  typedef struct {
    logic       d, e, r;
    logic [3:0] exp;   // {q_level, rise_pulse, fall_pulse, busy}
  } vec_t;
  vec_t tbl[18];

  function automatic logic [3:0] dut_vec();
    return {q_level, rise_pulse, fall_pulse, busy};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b ({q,rise,fall,busy}) t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic d, input logic e, input logic r);
    logic s;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!r) begin
      m_hist = '0;
      m_lvl  = 1'b0;
      m_run  = 0;
    end else begin
      s = m_hist[SYNC-1];
      if (!e || s == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == STABLE) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) m_rise = 1'b1;
          else       m_fall = 1'b1;
        end
      end
      m_hist = {m_hist[SYNC-2:0], d};
    end
  endtask

  task automatic start_seq();
    seq_idx  = 0;
    rise_cnt = 0;
    fall_cnt = 0;
    rise_at  = -1;
  endtask

  task automatic tick(input logic d, input logic e, input logic r);
    @(negedge clk);
    din = d; en = e; rst = r;
    @(posedge clk);
    model_edge(d, e, r);
    #1;
    chk("model", dut_vec(), {m_lvl, m_rise, m_fall, (m_run != 0)});
    if (rise_pulse) begin rise_cnt++; rise_at = seq_idx; end
    if (fall_pulse) fall_cnt++;
    seq_idx++;
  endtask

  initial begin
    int   len;
    logic rd, re, rr;

    // Reset held 3 cycles with din=1, release, rise at edge 5, then clean fall.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'b0001};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'b0001};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'b0001};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b1100};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 4'b1001};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 4'b0010};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 4'b0000};

    din = 1'b1;
    start_seq();
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].d, tbl[i].e, tbl[i].r);
      chk($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Bounce 1,0,1,1,0,1,1,1,1 then steady 1: single rise once 4 ones are seen.
    begin
      logic [8:0] bpat;
      bpat = 9'b111101101;   // bit i is the din value of cycle i
      start_seq();
      for (int i = 0; i < 9; i++) tick(bpat[i], 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b1);
      chk_int("bounce_rise_cnt", rise_cnt, 1);
      chk_int("bounce_rise_at", rise_at, 10);
    end

    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);

    // Glitch just before completion forces a fresh run of 4.
    start_seq();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b1);
    chk_int("glitch_rise_cnt", rise_cnt, 1);
    chk_int("glitch_rise_at", rise_at, 9);

    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);

    // Enable low while din rises: frozen; raising en qualifies from cnt=1.
    start_seq();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
    chk_int("en_off_rise_cnt", rise_cnt, 0);
    chk("en_off_state", dut_vec(), 4'b0000);
    start_seq();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1);
    chk_int("en_on_rise_cnt", rise_cnt, 1);
    chk_int("en_on_rise_at", rise_at, 3);

    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);

    // Reset when cnt=2: count abandoned, then a full new qualification.
    start_seq();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk_int("rstmid_rise_cnt", rise_cnt, 0);
    chk("rstmid_state", dut_vec(), 4'b0000);
    start_seq();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b1);
    chk_int("rstmid_after_rise_cnt", rise_cnt, 1);
    chk_int("rstmid_after_rise_at", rise_at, 5);

    // Random runs of din with occasional enable drops and resets.
    start_seq();
    for (int i = 0; i < 300; i++) begin
      len = $urandom_range(1, 7);
      rd  = 1'($urandom_range(0, 1));
      re  = ($urandom_range(0, 9) != 0);
      rr  = ($urandom_range(0, 39) != 0);
      for (int j = 0; j < len; j++) tick(rd, re, rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
